// File: rtl/siso_llr_pingpong_buffer.sv
// siso_llr_pingpong_buffer: two-bank LLR staging buffer; one bank loads while the SISO core reads the other
module siso_llr_pingpong_buffer #(
  parameter int DATA_W     = 16,
  parameter int MAX_BLKLEN = 6144,
  parameter int BLK_ALIGN  = 8,
  parameter int ADDR_W     = $clog2(MAX_BLKLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] apriori,
  input  logic              valid_apriori,
  input  logic [15:0]       blklen,
  input  logic              valid_blklen,
  output logic              ready,
  input  logic              rd_start,
  input  logic              rd_reverse,
  output logic [DATA_W-1:0] sys_o,
  output logic [DATA_W-1:0] par_o,
  output logic [DATA_W-1:0] apr_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              out_ready,
  output logic              blk_avail,
  output logic [15:0]       blklen_o,
  output logic              err_blklen,
  output logic              err_overrun
);
  localparam int CW = ADDR_W + 1;
  localparam int EW = 3 * DATA_W + 1;
  typedef enum logic {W_IDLE, W_LOAD} wstate_t;
  typedef enum logic {R_IDLE, R_RUN} rstate_t;
  wstate_t ws;
  rstate_t rs;
  logic              wsel, rsel, alive, rev, p, p_last;
  logic [1:0]        full, wset, rclr, cnt;
  logic [15:0]       klen [2];
  logic [CW-1:0]     in_cnt, apr_cnt, kw, kr, left;
  logic [ADDR_W-1:0] raddr, a;
  logic [DATA_W-1:0] sys_mem [2][MAX_BLKLEN];
  logic [DATA_W-1:0] par_mem [2][MAX_BLKLEN];
  logic [DATA_W-1:0] apr_mem [2][MAX_BLKLEN];
  logic [DATA_W-1:0] sys_q, par_q, apr_q;
  logic [EW-1:0]     e0, e1, din;
  logic legal, w_ok, in_acc, apr_acc, in_fin, apr_fin, wdone, rfire, issue, pop, rdone;

  assign kw        = CW'(klen[wsel]);
  assign kr        = CW'(klen[rsel]);
  assign legal     = blklen != 16'd0 && blklen <= 16'(MAX_BLKLEN) && (blklen % 16'(BLK_ALIGN)) == 16'd0;
  // alive keeps ready low until the first clock after reset release
  assign ready     = alive && ws == W_IDLE && !full[wsel];
  assign w_ok      = valid_blklen && ready && legal;
  assign in_acc    = ws == W_LOAD && valid_in && in_cnt != (kw << 1);
  assign apr_acc   = ws == W_LOAD && valid_apriori && apr_cnt != kw;
  assign in_fin    = (in_cnt + CW'(in_acc)) == (kw << 1);
  assign apr_fin   = (apr_cnt + CW'(apr_acc)) == kw;
  assign wdone     = ws == W_LOAD && in_fin && apr_fin;
  assign blk_avail = rs == R_IDLE ? full[rsel] : full[~rsel];
  assign rfire     = rs == R_IDLE && rd_start && blk_avail;
  assign valid_o   = cnt != 2'd0;
  assign pop       = valid_o && out_ready;
  // issue only when the skid buffer has room for everything already in flight
  assign issue     = rfire || (rs == R_RUN && left != '0 && (cnt + {1'b0, p}) <= (2'd1 + {1'b0, pop}));
  assign a         = rfire ? (rd_reverse ? ADDR_W'(kr - CW'(1)) : '0) : raddr;
  assign rdone     = pop && e0[0];
  assign din       = {sys_q, par_q, apr_q, p_last};
  assign {sys_o, par_o, apr_o, last_o} = e0;
  assign wset      = {1'b0, wdone} << wsel;
  assign rclr      = {1'b0, rdone} << rsel;

  always_ff @(posedge clk) begin
    if (in_acc && !in_cnt[0]) sys_mem[wsel][in_cnt[CW-1:1]] <= in;
    if (in_acc && in_cnt[0]) par_mem[wsel][in_cnt[CW-1:1]] <= in;
    if (apr_acc) apr_mem[wsel][apr_cnt[ADDR_W-1:0]] <= apriori;
    if (issue) begin
      sys_q <= sys_mem[rsel][a];
      par_q <= par_mem[rsel][a];
      apr_q <= apr_mem[rsel][a];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws          <= W_IDLE;
      rs          <= R_IDLE;
      wsel        <= 1'b0;
      rsel        <= 1'b0;
      alive       <= 1'b0;
      rev         <= 1'b0;
      p           <= 1'b0;
      p_last      <= 1'b0;
      full        <= '0;
      cnt         <= '0;
      klen        <= '{default: '0};
      in_cnt      <= '0;
      apr_cnt     <= '0;
      left        <= '0;
      raddr       <= '0;
      e0          <= '0;
      e1          <= '0;
      blklen_o    <= '0;
      err_blklen  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      alive <= 1'b1;
      full  <= (full | wset) & ~rclr;
      if (valid_blklen && !w_ok) err_blklen <= 1'b1;
      if ((valid_in && !in_acc) || (valid_apriori && !apr_acc)) err_overrun <= 1'b1;
      if (w_ok) begin
        ws         <= W_LOAD;
        klen[wsel] <= blklen;
        in_cnt     <= '0;
        apr_cnt    <= '0;
      end else if (ws == W_LOAD) begin
        in_cnt  <= in_cnt + CW'(in_acc);
        apr_cnt <= apr_cnt + CW'(apr_acc);
        if (wdone) begin
          ws   <= W_IDLE;
          wsel <= ~wsel;
        end
      end
      if (rfire) begin
        rs       <= R_RUN;
        rev      <= rd_reverse;
        blklen_o <= klen[rsel];
      end else if (rdone) begin
        rs   <= R_IDLE;
        rsel <= ~rsel;
      end
      p <= issue;
      if (issue) begin
        p_last <= (rfire ? kr : left) == CW'(1);
        left   <= (rfire ? kr : left) - CW'(1);
        raddr  <= (rfire ? rd_reverse : rev) ? a - ADDR_W'(1) : a + ADDR_W'(1);
      end
      cnt <= cnt + {1'b0, p} - {1'b0, pop};
      if (pop) e0 <= cnt == 2'd2 ? e1 : din;
      else if (p && cnt == 2'd0) e0 <= din;
      if (p && cnt == (pop ? 2'd2 : 2'd1)) e1 <= din;
    end
  end
endmodule
